// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: memory request/response channel, redirect input and decode handoff.
// The master modport is the fetch unit's side of the bus; the slave modport is the side facing it.
interface instr_fetch_if #(
  parameter int unsigned wd_instr_p = 32,
  parameter int unsigned wd_addr_p  = 32
);
  logic                  o_mem_req;
  logic [wd_addr_p-1:0]  o_mem_addr;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [wd_instr_p-1:0] i_mem_rdata;
  logic                  i_redirect;
  logic [wd_addr_p-1:0]  i_redirect_pc;
  logic                  o_valid;
  logic [wd_instr_p-1:0] o_instr;
  logic [wd_addr_p-1:0]  o_pc;
  logic                  i_ready;

  modport master (
    output o_mem_req, o_mem_addr, o_valid, o_instr, o_pc,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_valid, o_instr, o_pc,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited in-order memory requests into a first-word-fall-through
// buffer; a redirect flushes the buffer and drains in-flight responses before refetching.
module instr_fetch #(
  parameter int unsigned          wd_instr_p = 32,
  parameter int unsigned          wd_addr_p  = 32,
  parameter logic [wd_addr_p-1:0] reset_pc_p = 32'h0000_0000,
  parameter int unsigned          depth_p    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);

  localparam int unsigned cnt_w  = $clog2(depth_p + 1);
  localparam int unsigned cnt_w1 = cnt_w + 1;
  localparam int unsigned ptr_w  = (depth_p > 1) ? $clog2(depth_p) : 1;

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e                state_q;
  logic [wd_addr_p-1:0]  fetch_pc_q, resp_pc_q;
  logic [cnt_w-1:0]      outst_q, occ_q;
  logic [ptr_w-1:0]      head_q, tail_q;
  logic [wd_instr_p-1:0] instr_mem_q [depth_p];
  logic [wd_addr_p-1:0]  pc_mem_q    [depth_p];

  logic [cnt_w1-1:0]     credit_used_c;
  logic                  mem_req_c, grant_c, rvalid_c, push_c, pop_c, valid_c;
  logic [cnt_w-1:0]      outst_nxt_c;
  logic [wd_addr_p-1:0]  redirect_pc_c;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Credit rule: in-flight requests plus buffered words never exceed the buffer depth.
  always_comb begin
    credit_used_c = cnt_w1'(outst_q) + cnt_w1'(occ_q);
    valid_c       = (occ_q != '0);
    mem_req_c     = rst_n && (state_q == FETCH) && !bus.i_redirect &&
                    (credit_used_c < cnt_w1'(depth_p));
    grant_c       = mem_req_c && bus.i_mem_gnt;
    rvalid_c      = bus.i_mem_rvalid && (outst_q != '0);
    push_c        = rvalid_c && (state_q == FETCH) && !bus.i_redirect;
    pop_c         = valid_c && bus.i_ready && !bus.i_redirect;
    outst_nxt_c   = outst_q + cnt_w'(grant_c) - cnt_w'(rvalid_c);
    redirect_pc_c = {bus.i_redirect_pc[wd_addr_p-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= reset_pc_p;
      resp_pc_q  <= reset_pc_p;
      outst_q    <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      outst_q <= outst_nxt_c;
      if (bus.i_redirect) begin
        fetch_pc_q <= redirect_pc_c;
        resp_pc_q  <= redirect_pc_c;
        occ_q      <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        state_q    <= (outst_nxt_c != '0) ? DRAIN : FETCH;
      end else begin
        if (grant_c) fetch_pc_q <= fetch_pc_q + wd_addr_p'(4);
        if (push_c) begin
          tail_q    <= ptr_inc(tail_q);
          resp_pc_q <= resp_pc_q + wd_addr_p'(4);
        end
        if (pop_c) head_q <= ptr_inc(head_q);
        occ_q <= occ_q + cnt_w'(push_c) - cnt_w'(pop_c);
        // Leave DRAIN as soon as the last stale response has been swallowed.
        if ((state_q == DRAIN) && (outst_nxt_c == '0)) state_q <= FETCH;
      end
    end
  end

  // Buffer storage needs no reset: occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[tail_q] <= bus.i_mem_rdata;
      pc_mem_q[tail_q]    <= resp_pc_q;
    end
  end

  assign bus.o_mem_req  = mem_req_c;
  assign bus.o_mem_addr = fetch_pc_q;
  assign bus.o_valid    = valid_c;
  assign bus.o_instr    = valid_c ? instr_mem_q[head_q] : '0;
  assign bus.o_pc       = valid_c ? pc_mem_q[head_q]    : '0;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL take parameter wd_instr_p, default 32, instruction width.
REQ-002 SHALL take parameter wd_addr_p, default 32, PC/address width.
REQ-003 SHALL take parameter reset_pc_p, default 32'h0000_0000, first fetch address.
REQ-004 SHALL take parameter depth_p, default 2, output buffer depth and max outstanding requests (>=1).
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge clk.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port o_mem_req  out  1  fetch request valid.
REQ-008 SHALL have port o_mem_addr  out  wd_addr_p  fetch address, word aligned.
REQ-009 SHALL have port i_mem_gnt  in  1  request accepted this cycle when o_mem_req=1.
REQ-010 SHALL have port i_mem_rvalid  in  1  read data valid; in order, one per grant, earliest the cycle after grant.
REQ-011 SHALL have port i_mem_rdata  in  wd_instr_p  fetched instruction word.
REQ-012 SHALL have port i_redirect  in  1  jump/branch taken; flush and refetch.
REQ-013 SHALL have port i_redirect_pc  in  wd_addr_p  redirect target.
REQ-014 SHALL have port o_valid  out  1  instruction available to decode.
REQ-015 SHALL have port o_instr  out  wd_instr_p  instruction to decode stage.
REQ-016 SHALL have port o_pc  out  wd_addr_p  PC of o_instr.
REQ-017 SHALL have port i_ready  in  1  decode accepts o_instr when o_valid=1.

Function
REQ-018 SHALL hold fetch_pc (next request address) and resp_pc (PC of next kept response); o_mem_addr = fetch_pc.
REQ-019 SHALL implement states FETCH and DRAIN; FETCH after reset.
REQ-020 SHALL assert o_mem_req in FETCH only when i_redirect=0 and outstanding + buffer occupancy < depth_p (credit rule; buffer never overflows).
REQ-021 SHALL, once o_mem_req=1 without i_mem_gnt, keep o_mem_req and o_mem_addr stable until grant, unless i_redirect.
REQ-022 SHALL on o_mem_req & i_mem_gnt increment outstanding and set fetch_pc = fetch_pc + 4, wrapping modulo 2^wd_addr_p.
REQ-023 SHALL on i_mem_rvalid decrement outstanding; in FETCH push {resp_pc, i_mem_rdata} into buffer and set resp_pc += 4 (wrapping); in DRAIN discard the word.
REQ-024 SHALL present buffer head on o_instr/o_pc with o_valid = buffer non-empty; pop on o_valid & i_ready; push and pop same cycle keeps occupancy.
REQ-025 SHALL be first-word-fall-through: word received in cycle N gives o_valid=1 in cycle N+1.
REQ-026 SHALL on i_redirect (either state): empty buffer, set fetch_pc and resp_pc to {i_redirect_pc[wd_addr_p-1:2], 2'b00}, suppress o_mem_req that cycle, ignore same-cycle i_ready pop and any same-cycle rvalid data.
REQ-027 SHALL after redirect enter DRAIN if outstanding (after same-cycle rvalid decrement) > 0, else FETCH.
REQ-028 SHALL in DRAIN keep o_mem_req=0, discard all responses, return to FETCH the cycle after outstanding reaches 0.
REQ-029 SHALL ignore i_mem_rvalid when outstanding = 0 (no underflow).
REQ-030 SHALL size outstanding counter to hold 0..depth_p.

Reset
REQ-031 SHALL on rst_n=0 set fetch_pc=resp_pc=reset_pc_p, outstanding=0, buffer empty, state FETCH; o_mem_req=0, o_valid=0, o_instr=0, o_pc=0.
REQ-032 SHALL on reset mid-operation drop all buffered data and forget outstanding requests; first request after release is reset_pc_p.

Verification
REQ-033 SHALL cover: reset release, gnt=1, 1-cycle memory latency, i_ready=1 -> addrs 0x0,0x4,0x8 issued back to back; o_pc 0x0,0x4,0x8 with matching data.
REQ-034 SHALL cover: i_ready=0, depth_p=2 -> exactly 2 requests granted then o_mem_req=0; raising i_ready resumes requests, no word lost or duplicated.
REQ-035 SHALL cover: gnt held 0 for 3 cycles -> o_mem_req=1 and o_mem_addr unchanged all 3 cycles.
REQ-036 SHALL cover: redirect to 0x103 with 2 outstanding -> DRAIN, both responses discarded, next request 0x100, first o_pc=0x100.
REQ-037 SHALL cover: redirect with 0 outstanding and same-cycle pop -> buffer empty next cycle, request 0x(target) next cycle, stays FETCH.
REQ-038 SHALL cover: fetch_pc=0xFFFF_FFFC granted -> next o_mem_addr 0x0000_0000; rst_n low mid-DRAIN -> FETCH, request reset_pc_p.
